// File: rtl/pp_accum_pkg.sv
// Shared definitions for the iterative partial-product accumulator:
// FSM state encoding and beat-count sizing helpers.
package pp_accum_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_FINAL = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  // Two partial products are consumed per beat.
  function automatic int beats_of(input int pp_num);
    return (pp_num + 1) / 2;
  endfunction

  function automatic int cnt_width(input int beats);
    return (beats > 1) ? $clog2(beats) : 1;
  endfunction

endpackage

// File: rtl/pp_accum_scheduler_compressor4_2.sv
// compressor4_2: bitwise 4:2 compressor, 2*LENGTH wide.
// Contract: 2*C + D + 2*co == i0+i1+i2+i3+ci (mod 2^(2*LENGTH)).
module compressor4_2 #(
  parameter int LENGTH = 32
) (
  input  logic [2*LENGTH-1:0] i0,
  input  logic [2*LENGTH-1:0] i1,
  input  logic [2*LENGTH-1:0] i2,
  input  logic [2*LENGTH-1:0] i3,
  input  logic                ci,
  output logic [2*LENGTH-1:0] c,
  output logic [2*LENGTH-1:0] d,
  output logic                co
);

  localparam int W = 2 * LENGTH;

  logic [W-1:0] s1;
  logic [W-2:0] k;
  logic [W-1:0] cin;

  genvar gi;
  generate
    for (gi = 0; gi < W; gi++) begin : g_bit
      assign s1[gi] = i0[gi] ^ i1[gi] ^ i2[gi];
      if (gi < W - 1) begin : g_k
        assign k[gi] = (i0[gi] & i1[gi]) | (i0[gi] & i2[gi]) | (i1[gi] & i2[gi]);
      end
      // Bit 0 takes ci; bit 1's slot is left empty because k[0] leaves as co.
      if (gi == 0) begin : g_cin0
        assign cin[gi] = ci;
      end else if (gi == 1) begin : g_cin1
        assign cin[gi] = 1'b0;
      end else begin : g_cinn
        assign cin[gi] = k[gi-1];
      end
      assign d[gi] = s1[gi] ^ i3[gi] ^ cin[gi];
      assign c[gi] = (s1[gi] & i3[gi]) | (s1[gi] & cin[gi]) | (i3[gi] & cin[gi]);
    end
  endgenerate

  assign co = k[0];

endmodule

// File: rtl/pp_accum_scheduler.sv
// Iterative Booth partial-product reducer around one compressor4_2 plus a final CPA.
// Optional shadow self-check enabled by defining PP_ACCUM_CHECK_EN.
module pp_accum_scheduler
  import pp_accum_pkg::*;
#(
  parameter int LENGTH = 32,
  parameter int PP_NUM = 17
) (
  input  logic                sys_clk,
  input  logic                sys_rst_n,
  input  logic                start,
  input  logic                pp_valid,
  output logic                pp_ready,
  input  logic [2*LENGTH-1:0] pp0,
  input  logic [2*LENGTH-1:0] pp1,
  output logic                prod_valid,
  input  logic                prod_ready,
  output logic [2*LENGTH-1:0] prod,
  output logic                busy,
  output logic                chk_err
);

  localparam int W = 2 * LENGTH;
  localparam int BEATS = beats_of(PP_NUM);
  localparam int CW = cnt_width(BEATS);
  localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);
  localparam bit ODD_PP = (PP_NUM % 2) == 1;

  logic [1:0]    state_reg, state_next;
  logic [W-1:0]  a_reg, b_reg, prod_reg;
  logic          ci_reg;
  logic [CW-1:0] beat_cnt_reg;
  logic          last_beat, beat_fire, op_start;
  logic [W-1:0]  pp1_masked, c_w, d_w, final_sum;
  logic          co_w;

  assign last_beat  = (beat_cnt_reg == LAST_BEAT);
  assign beat_fire  = (state_reg == ST_ACCUM) && pp_valid;
  assign op_start   = (state_reg == ST_IDLE) && start;
  assign pp1_masked = (ODD_PP && last_beat) ? '0 : pp1;
  assign final_sum  = a_reg + b_reg + W'(ci_reg);

  compressor4_2 #(.LENGTH(LENGTH)) u_comp (
    .i0 (a_reg),
    .i1 (b_reg),
    .i2 (pp0),
    .i3 (pp1_masked),
    .ci (ci_reg),
    .c  (c_w),
    .d  (d_w),
    .co (co_w)
  );

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:  if (start) state_next = ST_ACCUM;
      ST_ACCUM: if (beat_fire && last_beat) state_next = ST_FINAL;
      ST_FINAL: state_next = ST_DONE;
      ST_DONE:  if (prod_ready) state_next = ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    pp_ready   = (state_reg == ST_ACCUM);
    prod_valid = (state_reg == ST_DONE);
    busy       = (state_reg != ST_IDLE);
  end

  // Co has weight 2: it lands both in B[0] and in the carry-in for the next beat.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      a_reg        <= '0;
      b_reg        <= '0;
      ci_reg       <= 1'b0;
      beat_cnt_reg <= '0;
      prod_reg     <= '0;
    end else begin
      if (op_start) begin
        a_reg        <= '0;
        b_reg        <= '0;
        ci_reg       <= 1'b0;
        beat_cnt_reg <= '0;
      end else if (beat_fire) begin
        a_reg        <= d_w;
        b_reg        <= (c_w << 1) | W'(co_w);
        ci_reg       <= co_w;
        beat_cnt_reg <= beat_cnt_reg + CW'(1);
      end
      if (state_reg == ST_FINAL) prod_reg <= final_sum;
    end
  end

  assign prod = prod_reg;

`ifdef PP_ACCUM_CHECK_EN
  logic [W-1:0] ref_sum_reg;
  logic         chk_err_reg;

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      ref_sum_reg <= '0;
      chk_err_reg <= 1'b0;
    end else begin
      if (op_start)       ref_sum_reg <= '0;
      else if (beat_fire) ref_sum_reg <= ref_sum_reg + pp0 + pp1_masked;
      if ((state_reg == ST_FINAL) && (final_sum != ref_sum_reg)) chk_err_reg <= 1'b1;
    end
  end

  assign chk_err = chk_err_reg;
`else
  assign chk_err = 1'b0;
`endif

endmodule
